// File: rtl/demux_stream_scheduler.sv
// Steers a valid/ready input stream onto four output channels, round-robin in
// bursts of BURST_LEN beats or fixed to one channel, through a one-beat output register.
module demux_stream_scheduler #(
  parameter int DW        = 8,
  parameter int BURST_LEN = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  output logic          in_ready,
  input  logic          mode,
  input  logic [1:0]    fix_sel,
  input  logic [3:0]    ch_en,
  output logic [3:0]    out_valid,
  output logic [DW-1:0] out_data,
  input  logic [3:0]    out_ready,
  output logic [1:0]    cur_sel,
  output logic [7:0]    beat_cnt
);

  localparam logic [7:0] BurstLen = 8'(BURST_LEN);

  logic          buf_valid_q, buf_valid_d;
  logic [1:0]    buf_sel_q, buf_sel_d;
  logic [DW-1:0] buf_data_q, buf_data_d;
  logic [1:0]    ptr_q, ptr_d;
  logic [7:0]    cnt_q, cnt_d;

  logic [1:0]    tgt;
  logic          drain;
  logic          capture;
  logic [7:0]    burst_n;

  // First enabled channel after p, searching p+1, p+2, p+3 and finally p itself.
  function automatic logic [1:0] next_en(input logic [1:0] p, input logic [3:0] en);
    logic [1:0] r;
    logic [1:0] c;
    r = p;
    for (int k = 3; k >= 1; k--) begin
      c = p + 2'(k);
      if (en[c]) r = c;
    end
    return r;
  endfunction

  always_comb begin
    tgt      = mode ? fix_sel : (ch_en[ptr_q] ? ptr_q : next_en(ptr_q, ch_en));
    drain    = buf_valid_q && out_ready[buf_sel_q];
    in_ready = rst_n && ch_en[tgt] && (!buf_valid_q || drain);
    capture  = in_valid && in_ready;
    burst_n  = ((tgt == ptr_q) ? cnt_q : 8'd0) + 8'd1;
  end

  // NOTE: every next-state signal takes its held value first, so no path infers a latch.
  always_comb begin
    buf_valid_d = buf_valid_q;
    buf_sel_d   = buf_sel_q;
    buf_data_d  = buf_data_q;
    ptr_d       = ptr_q;
    cnt_d       = cnt_q;
    if (capture) begin
      buf_valid_d = 1'b1;
      buf_sel_d   = tgt;
      buf_data_d  = in_data;
      if (!mode) begin
        if (burst_n == BurstLen) begin
          ptr_d = next_en(tgt, ch_en);
          cnt_d = 8'd0;
        end else begin
          ptr_d = tgt;
          cnt_d = burst_n;
        end
      end
    end else if (drain) begin
      buf_valid_d = 1'b0;
    end
  end

  // NOTE: non-blocking assignments so every register updates from pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      buf_valid_q <= 1'b0;
      buf_sel_q   <= 2'd0;
      // NOTE: the data register is reset too because it drives out_data directly.
      buf_data_q  <= '0;
      ptr_q       <= 2'd0;
      cnt_q       <= 8'd0;
    end else begin
      buf_valid_q <= buf_valid_d;
      buf_sel_q   <= buf_sel_d;
      buf_data_q  <= buf_data_d;
      ptr_q       <= ptr_d;
      cnt_q       <= cnt_d;
    end
  end

  assign out_valid = buf_valid_q ? (4'b0001 << buf_sel_q) : 4'b0000;
  assign out_data  = buf_data_q;
  assign cur_sel   = ptr_q;
  assign beat_cnt  = cnt_q;

endmodule

// File: tb/tb_demux_stream_scheduler.sv
// Bench for demux_stream_scheduler: directed scenarios plus a random phase, every
// cycle compared against a beat-level reference model of the scheduling rules.
module tb_demux_stream_scheduler;

  localparam int DW = 8;
  localparam int BL = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          in_ready;
  logic          mode;
  logic [1:0]    fix_sel;
  logic [3:0]    ch_en;
  logic [3:0]    out_valid;
  logic [DW-1:0] out_data;
  logic [3:0]    out_ready;
  logic [1:0]    cur_sel;
  logic [7:0]    beat_cnt;

  int n_checks = 0;
  int n_errors = 0;
  bit check_en = 1'b0;

  // Reference model state: one buffered beat plus the burst pointer and count.
  bit            m_valid;
  int            m_sel;
  int            m_ptr;
  int            m_cnt;
  logic [DW-1:0] m_data;

  // Beats seen leaving the DUT (channel, data), in delivery order.
  int            log_ch[$];
  logic [DW-1:0] log_data[$];

  demux_stream_scheduler #(.DW(DW), .BURST_LEN(BL)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .mode      (mode),
    .fix_sel   (fix_sel),
    .ch_en     (ch_en),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .cur_sel   (cur_sel),
    .beat_cnt  (beat_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // First enabled channel scanning p, p+1, p+2, p+3 (mod 4).
  function automatic int first_en(input int p, input logic [3:0] en);
    for (int k = 0; k < 4; k++) begin
      int c;
      c = (p + k) % 4;
      if (en[c]) return c;
    end
    return p % 4;
  endfunction

  function automatic int model_tgt();
    return mode ? int'(fix_sel) : first_en(m_ptr, ch_en);
  endfunction

  function automatic bit model_ready();
    int  t;
    bit  drn;
    t   = model_tgt();
    drn = m_valid && out_ready[m_sel];
    return (rst_n === 1'b1) && ch_en[t] && (!m_valid || drn);
  endfunction

  // One clock: compare mid-cycle, log deliveries, then advance the model at the edge.
  task automatic step(input string tag);
    int t;
    int n;
    bit drn;
    bit cap;
    #1;
    if (check_en) begin
      check({tag, ".in_ready"},  32'(in_ready),  32'(model_ready()));
      check({tag, ".out_valid"}, 32'(out_valid), m_valid ? (32'd1 << m_sel) : 32'd0);
      check({tag, ".out_data"},  32'(out_data),  32'(m_data));
      check({tag, ".cur_sel"},   32'(cur_sel),   32'(m_ptr));
      check({tag, ".beat_cnt"},  32'(beat_cnt),  32'(m_cnt));
      check({tag, ".onehot"},    32'($countones(out_valid) <= 1), 32'd1);
      for (int c = 0; c < 4; c++) begin
        if (out_valid[c] && out_ready[c]) begin
          log_ch.push_back(c);
          log_data.push_back(out_data);
        end
      end
    end
    t   = model_tgt();
    drn = m_valid && out_ready[m_sel];
    cap = in_valid && model_ready();
    @(posedge clk);
    if (!rst_n) begin
      m_valid = 1'b0;
      m_sel   = 0;
      m_data  = '0;
      m_ptr   = 0;
      m_cnt   = 0;
    end else if (cap) begin
      m_valid = 1'b1;
      m_sel   = t;
      m_data  = in_data;
      if (!mode) begin
        n = ((t == m_ptr) ? m_cnt : 0) + 1;
        if (n == BL) begin
          m_ptr = first_en((t + 1) % 4, ch_en);
          m_cnt = 0;
        end else begin
          m_ptr = t;
          m_cnt = n;
        end
      end
    end else if (drn) begin
      m_valid = 1'b0;
    end
    #1;
  endtask

  task automatic check_log(input string tag, input int exp_ch[$], input logic [DW-1:0] exp_d[$]);
    check({tag, ".count"}, 32'(log_ch.size()), 32'(exp_ch.size()));
    for (int i = 0; i < exp_ch.size() && i < log_ch.size(); i++) begin
      check($sformatf("%s[%0d].ch", tag, i),   32'(log_ch[i]),   32'(exp_ch[i]));
      check($sformatf("%s[%0d].data", tag, i), 32'(log_data[i]), 32'(exp_d[i]));
    end
  endtask

  initial begin
    int            e_ch[$];
    logic [DW-1:0] e_d[$];

    // Reset and idle
    rst_n = 1'b0; in_valid = 1'b1; in_data = 8'h33; mode = 1'b0; fix_sel = 2'd0;
    ch_en = 4'b1111; out_ready = 4'b1111;
    step("rst0");
    check_en = 1'b1;
    step("rst1");
    step("rst2");
    rst_n = 1'b1; in_valid = 1'b0;
    #1;
    check("idle.in_ready", 32'(in_ready), 32'd1);
    step("idle");

    // Round-robin bursts, full throughput
    log_ch.delete(); log_data.delete(); e_ch.delete(); e_d.delete();
    for (int i = 0; i < 16; i++) begin
      in_valid = 1'b1; in_data = 8'(i);
      e_ch.push_back(i / 4); e_d.push_back(8'(i));
      step("rr");
    end
    in_valid = 1'b0;
    step("rr_tail");
    step("rr_tail");
    check_log("rr_log", e_ch, e_d);
    check("rr.cur_sel_end", 32'(cur_sel), 32'd0);

    // Back-pressure on ch0
    log_ch.delete(); log_data.delete(); e_ch.delete(); e_d.delete();
    in_valid = 1'b1; in_data = 8'hA5; out_ready = 4'b1111;
    step("bp_cap");
    for (int s = 0; s < 3; s++) begin
      out_ready = 4'b1110; in_valid = 1'b1; in_data = 8'h5A;
      #1;
      check("bp.out_valid", 32'(out_valid), 32'h1);
      check("bp.out_data",  32'(out_data),  32'hA5);
      check("bp.in_ready",  32'(in_ready),  32'd0);
      step("bp_stall");
    end
    out_ready = 4'b1111;
    step("bp_rel");
    in_valid = 1'b0;
    step("bp_out");
    step("bp_out");
    e_ch = '{0, 0}; e_d = '{8'hA5, 8'h5A};
    check_log("bp_log", e_ch, e_d);

    // Skip disabled channels, then drop the channel of the burst in progress
    rst_n = 1'b0; in_valid = 1'b0;
    step("sk_rst");
    rst_n = 1'b1; ch_en = 4'b1010;
    log_ch.delete(); log_data.delete(); e_ch.delete(); e_d.delete();
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1; in_data = 8'(8'h10 + i);
      e_ch.push_back((i < 4) ? 1 : 3); e_d.push_back(8'(8'h10 + i));
      step("skip");
    end
    in_data = 8'h20; step("skip");
    in_data = 8'h21; step("skip");
    ch_en = 4'b1000; in_data = 8'h22;
    #1;
    check("drop.cur_sel_before",  32'(cur_sel),   32'd1);
    check("drop.beat_cnt_before", 32'(beat_cnt),  32'd2);
    check("drop.out_valid_ch1",   32'(out_valid), 32'b0010);
    step("skip_drop");
    in_valid = 1'b0;
    #1;
    check("drop.cur_sel_after",  32'(cur_sel),   32'd3);
    check("drop.beat_cnt_after", 32'(beat_cnt),  32'd1);
    check("drop.out_valid_ch3",  32'(out_valid), 32'b1000);
    step("skip_tail");
    step("skip_tail");
    e_ch.push_back(1); e_d.push_back(8'h20);
    e_ch.push_back(1); e_d.push_back(8'h21);
    e_ch.push_back(3); e_d.push_back(8'h22);
    check_log("skip_log", e_ch, e_d);

    // Fixed mode with pointer and count frozen
    rst_n = 1'b0; step("fx_rst");
    rst_n = 1'b1; ch_en = 4'b1111; mode = 1'b0;
    log_ch.delete(); log_data.delete(); e_ch.delete(); e_d.delete();
    in_valid = 1'b1;
    in_data = 8'h30; step("fx_pre");
    in_data = 8'h31; step("fx_pre");
    e_ch = '{0, 0}; e_d = '{8'h30, 8'h31};
    mode = 1'b1; fix_sel = 2'd2;
    for (int i = 0; i < 10; i++) begin
      in_data = 8'(8'h40 + i);
      e_ch.push_back(2); e_d.push_back(8'(8'h40 + i));
      #1;
      check("fix.cur_sel",  32'(cur_sel),  32'd0);
      check("fix.beat_cnt", 32'(beat_cnt), 32'd2);
      step("fix");
    end
    in_valid = 1'b0;
    step("fix_tail");
    step("fix_tail");
    check_log("fix_log", e_ch, e_d);
    ch_en = 4'b1011; in_valid = 1'b1;
    #1;
    check("fix_dis.in_ready", 32'(in_ready), 32'd0);
    step("fix_dis");
    mode = 1'b0; ch_en = 4'b0000;
    #1;
    check("none_en.in_ready", 32'(in_ready), 32'd0);
    step("none_en");

    // Reset with a beat buffered mid-burst
    in_valid = 1'b0; ch_en = 4'b1111;
    rst_n = 1'b0; step("mr_rst0");
    rst_n = 1'b1;
    log_ch.delete(); log_data.delete(); e_ch.delete(); e_d.delete();
    in_valid = 1'b1;
    in_data = 8'h50; step("mr");
    in_data = 8'h51; step("mr");
    in_valid = 1'b0; out_ready = 4'b0000;
    #1;
    check("mr.beat_cnt_pre",  32'(beat_cnt),  32'd2);
    check("mr.out_valid_pre", 32'(out_valid), 32'b0001);
    check("mr.out_data_pre",  32'(out_data),  32'h51);
    step("mr_hold");
    rst_n = 1'b0;
    #1;
    check("mr.in_ready_rst", 32'(in_ready), 32'd0);
    step("mr_rst");
    rst_n = 1'b1;
    #1;
    check("mr.out_valid_post", 32'(out_valid), 32'b0000);
    check("mr.cur_sel_post",   32'(cur_sel),   32'd0);
    check("mr.beat_cnt_post",  32'(beat_cnt),  32'd0);
    out_ready = 4'b1111;
    step("mr_tail");
    step("mr_tail");
    e_ch = '{0}; e_d = '{8'h50};
    check_log("mr_log", e_ch, e_d);

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = 8'($urandom);
      out_ready = 4'($urandom);
      if ($urandom_range(0, 19) == 0) ch_en = 4'($urandom);
      if ($urandom_range(0, 29) == 0) mode = 1'($urandom);
      fix_sel   = 2'($urandom);
      rst_n     = ($urandom_range(0, 199) != 0);
      step("rnd");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
